// File: rtl/filter_arbiter.sv
// Round-robin, credit-limited sharing of one fixed-latency FilterBlock among N requesters.
// Define FILTER_ARB_STATS_EN to add per-requester saturating grant counters (stat_grants).
module filter_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned MAX_OUT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N-1:0]    req_valid,
  input  logic [N*16-1:0] req_data,
  input  logic [N-1:0]    req_parity,
  output logic [N-1:0]    req_ready,
  output logic [15:0]     f_x_data,
  output logic            f_x_valid,
  output logic            f_x_parity,
  input  logic [15:0]     f_y_data,
  input  logic            f_y_valid,
  input  logic            f_y_parity,
  output logic [N-1:0]    rsp_valid,
  output logic [15:0]     rsp_data,
  output logic            rsp_parity,
  output logic            idle,
  output logic            err
`ifdef FILTER_ARB_STATS_EN
  ,
  output logic [N*16-1:0] stat_grants
`endif
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);
  localparam int unsigned GW  = $clog2(LATENCY + 1);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan;
  logic           gnt_any;
  logic [N-1:0]   eligible;
  logic [15:0]    data_arr [N];
  logic [CW-1:0]  out_cnt [N];
  logic           tag_v [LATENCY+1];
  logic [IDW-1:0] tag_id [LATENCY+1];
  logic [GW-1:0]  guard;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign data_arr[gi] = req_data[gi*16 +: 16];
    assign eligible[gi] = req_valid[gi] & (out_cnt[gi] < CW'(MAX_OUT)) & enable;
  end

  // Rotating-priority scan starting just after the last winner
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    scan      = '0;
    for (int k = 1; k <= N; k++) begin
      scan = IDW'((int'(rr) + k) % N);
      if (!gnt_any && eligible[scan]) begin
        gnt_any = 1'b1;
        gnt_id  = scan;
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (out_cnt[i] != '0) idle = 1'b0;
    end
  end

  // guard masks filter results from words issued before reset for LATENCY cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr         <= IDW'(N - 1);
      f_x_valid  <= 1'b0;
      f_x_data   <= '0;
      f_x_parity <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_parity <= 1'b0;
      err        <= 1'b0;
      guard      <= GW'(LATENCY);
      for (int i = 0; i < N; i++) out_cnt[i] <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      f_x_valid <= gnt_any;
      if (gnt_any) begin
        rr         <= gnt_id;
        f_x_data   <= data_arr[gnt_id];
        f_x_parity <= req_parity[gnt_id];
      end

      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end

      rsp_valid <= tag_v[LATENCY] ? ({{(N-1){1'b0}}, 1'b1} << tag_id[LATENCY]) : '0;
      if (tag_v[LATENCY]) begin
        rsp_data   <= f_y_data;
        rsp_parity <= f_y_parity;
      end

      if (guard != '0) guard <= guard - GW'(1);
      else if (tag_v[LATENCY] != f_y_valid) err <= 1'b1;

      for (int i = 0; i < N; i++) begin
        case ({req_ready[i], rsp_valid[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CW'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CW'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

`ifdef FILTER_ARB_STATS_EN
  logic [15:0] grant_cnt [N];

  // Saturating per-requester grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && (grant_cnt[i] != 16'hFFFF)) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_stat
    assign stat_grants[gi*16 +: 16] = grant_cnt[gi];
  end
`endif

endmodule
